// File: rtl/mux_sel_ctrl.sv
// Select generator for the lab 2:1 mux. A raw push-button is synchronised and
// debounced, and each confirmed press toggles sel. A force input can override
// sel. Also provides a change pulse and a wrapping toggle counter for display.
module mux_sel_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic             force_en,
  input  logic             force_val,
  output logic             sel,
  output logic             sel_changed,
  output logic             btn_stable,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DebMax = DW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             s1_q, btn_s_q;
  logic             toggle_req;
  logic             sel_d;
  logic [CNT_W-1:0] toggle_cnt_d;

  // Debounce next-state: a level must be seen DEB_CYCLES+1 consecutive cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    toggle_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s_q) begin
          state_d = StPressWait;
          cnt_d   = DW'(1);
        end
      end
      StPressWait: begin
        if (!btn_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebMax) begin
          state_d    = StPressed;
          cnt_d      = '0;
          toggle_req = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      StPressed: begin
        if (!btn_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = DW'(1);
        end
      end
      StReleaseWait: begin
        // Bounce back high returns to PRESSED without a new toggle.
        if (btn_s_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DebMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Select next-state: force wins over a toggle request, which is then dropped.
  always_comb begin
    sel_d        = sel;
    toggle_cnt_d = toggle_cnt;
    if (force_en) begin
      sel_d = force_val;
    end else if (toggle_req) begin
      sel_d        = ~sel;
      toggle_cnt_d = toggle_cnt + CNT_W'(1);
    end
  end

  // Synchroniser, debounce FSM, and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      btn_stable  <= 1'b0;
      sel         <= 1'b0;
      sel_changed <= 1'b0;
      toggle_cnt  <= '0;
    end else begin
      s1_q        <= btn_raw;
      btn_s_q     <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_stable  <= (state_d == StPressed) || (state_d == StReleaseWait);
      sel         <= sel_d;
      sel_changed <= (sel_d != sel);
      toggle_cnt  <= toggle_cnt_d;
    end
  end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Upstream control stage for the lab 2:1 mux (`in0`/`in1`/`sel`/`out0`); it generates that mux's `sel` from a bouncy push-button.
- Synchronises and debounces the raw button, then toggles `sel` once per confirmed press.
- Provides a force override plus a change pulse and a toggle counter for LEDs/seven-segment display.

Parameters:
- DEB_CYCLES, 1000, consecutive stable synchronised cycles required to confirm a press or release (>=2).
- CNT_W, 4, width of toggle counter (wraps).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw asynchronous push-button, active high.
- force_en  input  1  when 1, sel follows force_val and debounced toggles are ignored.
- force_val  input  1  value loaded into sel while force_en=1.
- sel  output  1  registered select to the mux.
- sel_changed  output  1  one-cycle pulse on the cycle after sel changes value.
- btn_stable  output  1  debounced button level (1 in PRESSED/RELEASE_WAIT).
- toggle_cnt  output  CNT_W  count of debounced toggles applied to sel.

Behaviour:
- Reset (rst_n=0, async, any time, including mid-debounce):
  - sel=0, sel_changed=0, btn_stable=0, toggle_cnt=0.
  - Synchroniser flops=0; FSM=IDLE; debounce cnt=0.
  - Release is synchronous to clk.
- Synchroniser:
  - Two flops, btn_raw -> s1 -> btn_s.
  - A raw level sampled at edge N appears on btn_s after edge N+1.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Debounce cnt is ceil(log2(DEB_CYCLES+1)) bits.
  - IDLE: btn_s=1 -> PRESS_WAIT, cnt=1; else stay.
  - PRESS_WAIT:
    - btn_s=0 -> IDLE, cnt=0 (glitch rejected, no toggle).
    - cnt==DEB_CYCLES and btn_s=1 -> PRESSED, cnt=0, issue toggle request.
    - Otherwise cnt+1.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt=1; else stay (holding never re-toggles).
  - RELEASE_WAIT:
    - btn_s=1 -> PRESSED, cnt=0.
    - cnt==DEB_CYCLES and btn_s=0 -> IDLE.
    - Otherwise cnt+1.
- Latency: raw high first sampled at edge N and held -> PRESSED and sel toggled at edge N+2+DEB_CYCLES.
- sel register priority:
  1. force_en=1: sel<=force_val.
  2. Toggle request: sel<=~sel, toggle_cnt<=toggle_cnt+1 (wraps modulo 2^CNT_W).
  3. Otherwise hold.
- Simultaneous force and toggle request: force wins; the request is dropped, toggle_cnt is not incremented, and the FSM still enters PRESSED.
- sel_changed: registered, =1 for exactly one cycle after any edge where sel changed value (force or toggle); 0 when force reloads the same value.
- btn_stable: registered decode of FSM state.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 with btn_raw=1 and force_en=0 -> sel=0, toggle_cnt=0, sel_changed=0, btn_stable=0. Release rst_n with btn_raw held high -> a valid press is detected; sel=1 after 2+DEB_CYCLES further edges.
- Clean press, DEB_CYCLES=4: btn_raw 0->1 sampled at edge 10 and held 20 cycles -> sel=1 at edge 16, sel_changed=1 only in cycle after edge 16, toggle_cnt=1. Release and hold low 20 cycles -> sel stays 1, btn_stable=0 at edge 6+release sample edge.
- Bounce rejection, DEB_CYCLES=4: pulses of 1,2,3 cycles high separated by 2 cycles low, then a held press -> exactly one toggle, sel 0->1, toggle_cnt=1. A 3-cycle low glitch during a held press -> no second toggle.
- Force: force_en=1, force_val=1 -> sel=1 next edge with a one-cycle sel_changed. A clean press while forced -> sel stays 1, toggle_cnt unchanged. force_en=0 then a press -> sel=0, toggle_cnt+1.
- Wrap, CNT_W=4: 17 clean presses from reset -> toggle_cnt=1, sel=1.
- Async reset mid-debounce: assert rst_n low at edge 13 during PRESS_WAIT (between clock edges) -> outputs clear immediately without a clock edge, FSM=IDLE; no spurious toggle after release while btn_raw=0.
